// File: rtl/clock_and_reset_pkg.sv
// Shared types and helpers for the clock/reset monitor: measurement FSM states
// and a width-bounded saturating increment.
package clock_and_reset_pkg;

   typedef enum logic [1:0] {
      WAIT_RST = 2'd0,
      IN_RST   = 2'd1,
      POST_RST = 2'd2
   } mon_state_e;

   localparam int SAT_MAX_W = 64;

   // Increments v, but holds at 2^w-1; callers truncate the result to w bits.
   function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                    input int unsigned w);
      logic [SAT_MAX_W-1:0] max_v;
      max_v = (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
      return (v >= max_v) ? max_v : v + SAT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/clock_and_reset_monitor_if.sv
// Observed-reset input plus timeout control/status and reset-measurement results
// for the clock_and_reset_monitor.
interface clock_and_reset_monitor_if #(parameter int CNT_W = 32);
   logic             mon_reset_n;
   logic             tmo_load;
   logic [CNT_W-1:0] tmo_count;
   logic             tmo_cancel;
   logic             tmo_busy;
   logic [CNT_W-1:0] tmo_remaining;
   logic             tmo_expired;
   logic             tmo_toggle;
   logic [CNT_W-1:0] rst_len;
   logic             rst_len_valid;
   logic             rst_short_err;
   logic             rst_seen;
   logic [CNT_W-1:0] cycles_since_rst;

   modport master (
      output mon_reset_n, tmo_load, tmo_count, tmo_cancel,
      input  tmo_busy, tmo_remaining, tmo_expired, tmo_toggle,
      input  rst_len, rst_len_valid, rst_short_err, rst_seen, cycles_since_rst
   );

   modport slave (
      input  mon_reset_n, tmo_load, tmo_count, tmo_cancel,
      output tmo_busy, tmo_remaining, tmo_expired, tmo_toggle,
      output rst_len, rst_len_valid, rst_short_err, rst_seen, cycles_since_rst
   );
endinterface

// File: rtl/clock_timeout_counter.sv
// Programmable cycle-count timeout: load/cancel control, remaining count,
// one-cycle expiry pulse and an expiry toggle for cross-domain style signalling.
module clock_timeout_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_tmo_load,
   input  logic [CNT_W-1:0] i_tmo_count,
   input  logic             i_tmo_cancel,
   output logic             o_tmo_busy,
   output logic [CNT_W-1:0] o_tmo_remaining,
   output logic             o_tmo_expired,
   output logic             o_tmo_toggle
);

   logic             r_busy;
   logic [CNT_W-1:0] r_remaining;
   logic             r_expired;
   logic             r_toggle;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_busy      <= 1'b0;
         r_remaining <= '0;
         r_expired   <= 1'b0;
         r_toggle    <= 1'b0;
      end else begin
         r_expired <= 1'b0;
         // Load outranks both cancel and the final decrement step.
         if (i_tmo_load) begin
            r_remaining <= i_tmo_count;
            if (i_tmo_count == '0) begin
               r_busy    <= 1'b0;
               r_expired <= 1'b1;
               r_toggle  <= ~r_toggle;
            end else begin
               r_busy <= 1'b1;
            end
         end else if (i_tmo_cancel) begin
            r_busy      <= 1'b0;
            r_remaining <= '0;
         end else if (r_busy) begin
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
               r_busy    <= 1'b0;
               r_expired <= 1'b1;
               r_toggle  <= ~r_toggle;
            end
         end
      end
   end

   assign o_tmo_busy      = r_busy;
   assign o_tmo_remaining = r_remaining;
   assign o_tmo_expired   = r_expired;
   assign o_tmo_toggle    = r_toggle;

endmodule

// File: rtl/clock_and_reset_monitor.sv
// Receiving end of the generated clock/reset: measures observed reset pulses,
// tracks cycles since release and hosts the programmable timeout counter.
module clock_and_reset_monitor
   import clock_and_reset_pkg::*;
#(
   parameter int          CNT_W            = 32,
   parameter int unsigned MIN_RESET_CYCLES = 2
) (
   input logic                      clock,
   input logic                      reset,
   clock_and_reset_monitor_if.slave bus
);

   mon_state_e       r_state;
   logic             r_mon_q;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_rst_len;
   logic             r_rst_len_valid;
   logic             r_rst_short_err;
   logic             r_rst_seen;
   logic [CNT_W-1:0] r_cycles_since_rst;
   logic             w_fall;

   // A low sample following a high one starts a fresh measurement from any state.
   assign w_fall = r_mon_q && !bus.mon_reset_n;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state            <= WAIT_RST;
         r_mon_q            <= 1'b1;
         r_len              <= '0;
         r_rst_len          <= '0;
         r_rst_len_valid    <= 1'b0;
         r_rst_short_err    <= 1'b0;
         r_rst_seen         <= 1'b0;
         r_cycles_since_rst <= '0;
      end else begin
         r_mon_q         <= bus.mon_reset_n;
         r_rst_len_valid <= 1'b0;
         if (w_fall) begin
            r_state <= IN_RST;
            r_len   <= CNT_W'(1);
         end else begin
            case (r_state)
               IN_RST: begin
                  if (!bus.mon_reset_n) begin
                     r_len <= CNT_W'(sat_inc(SAT_MAX_W'(r_len), CNT_W));
                  end else begin
                     r_state            <= POST_RST;
                     r_rst_len          <= r_len;
                     r_rst_len_valid    <= 1'b1;
                     r_rst_seen         <= 1'b1;
                     r_cycles_since_rst <= '0;
                     r_rst_short_err    <= r_rst_short_err |
                                           (r_len < CNT_W'(MIN_RESET_CYCLES));
                  end
               end
               POST_RST: begin
                  r_cycles_since_rst <=
                     CNT_W'(sat_inc(SAT_MAX_W'(r_cycles_since_rst), CNT_W));
               end
               WAIT_RST: ;
               default: r_state <= WAIT_RST;
            endcase
         end
      end
   end

   assign bus.rst_len          = r_rst_len;
   assign bus.rst_len_valid    = r_rst_len_valid;
   assign bus.rst_short_err    = r_rst_short_err;
   assign bus.rst_seen         = r_rst_seen;
   assign bus.cycles_since_rst = r_cycles_since_rst;

   clock_timeout_counter #(.CNT_W(CNT_W)) u_tmo (
      .clock           (clock),
      .reset           (reset),
      .i_tmo_load      (bus.tmo_load),
      .i_tmo_count     (bus.tmo_count),
      .i_tmo_cancel    (bus.tmo_cancel),
      .o_tmo_busy      (bus.tmo_busy),
      .o_tmo_remaining (bus.tmo_remaining),
      .o_tmo_expired   (bus.tmo_expired),
      .o_tmo_toggle    (bus.tmo_toggle)
   );

endmodule

// File: doc/clock_and_reset_monitor.md
Name: clock_and_reset_monitor

Overview:
DUT-side receiving end of the clock/reset generator path. Runs on the generated clock and observes the generated active-low reset (mon_reset_n):
- measures each reset pulse length in cycles;
- flags pulses shorter than a minimum;
- counts cycles since the last reset release;
- provides a programmable cycle-count timeout with expiry pulse and toggle event, for timeouts and data-flush waits.

Parameters:
CNT_W, 32, width of all cycle counters and count ports
MIN_RESET_CYCLES, 2, minimum legal mon_reset_n low length in sampled edges

Ports:
clock  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high local reset
mon_reset_n  in  1  observed active-low reset, synchronous to clock
tmo_load  in  1  load timeout with tmo_count
tmo_count  in  CNT_W  timeout length in cycles
tmo_cancel  in  1  abort running timeout
tmo_busy  out  1  timeout running
tmo_remaining  out  CNT_W  cycles left
tmo_expired  out  1  one-cycle expiry pulse
tmo_toggle  out  1  inverts on every expiry
rst_len  out  CNT_W  length of last completed reset pulse, saturating
rst_len_valid  out  1  one-cycle pulse when rst_len updates
rst_short_err  out  1  sticky: a pulse shorter than MIN_RESET_CYCLES was seen
rst_seen  out  1  sticky: at least one complete pulse seen
cycles_since_rst  out  CNT_W  cycles since last release, saturating

Behaviour:
- Reset (reset=1 at posedge):
  - all outputs 0; internal mon_q=1 (observed reset treated as deasserted); FSM=WAIT_RST; internal len=0.
  - Reset wins over every other input, including mid-measurement and mid-timeout.
- Reset measurement FSM, states WAIT_RST, IN_RST, POST_RST:
  - Falling edge: mon_reset_n=0 sampled while mon_q=1, from any state → IN_RST, len<=1.
  - In IN_RST, each edge with mon_reset_n=0 → len<=len+1, saturating at 2^CNT_W-1.
  - Rising edge: mon_reset_n=1 sampled in IN_RST → POST_RST, and in the same edge:
    - rst_len<=len
    - rst_len_valid<=1 for exactly one cycle
    - rst_seen<=1
    - cycles_since_rst<=0
    - rst_short_err<=rst_short_err|(len<MIN_RESET_CYCLES)
  - Result: a pulse low for L sampled edges gives rst_len=L.
  - In POST_RST, cycles_since_rst increments each edge, saturating. It is held at its value while in IN_RST and stays 0 in WAIT_RST.
  - mon_q<=mon_reset_n every edge.
  - A new falling edge in POST_RST restarts measurement; rst_len keeps its old value until the next release.
- Timeout counter:
  - Load N>0: tmo_busy=1, tmo_remaining=N. Decrement each following edge.
  - On the edge where tmo_remaining goes 1→0: tmo_busy<=0, tmo_expired<=1 for one cycle, tmo_toggle inverts.
  - Expiry pulse is therefore visible N cycles after the load edge.
  - Load N=0: no busy; tmo_expired pulses in the next cycle and tmo_toggle inverts.
  - Load while busy: restart with the new count, no pulse.
  - Load on the same edge as the 1→0 step: load wins, expiry suppressed, toggle unchanged.
  - Cancel: busy<=0, remaining<=0, no pulse, toggle unchanged.
  - Cancel and load on the same edge: load wins.
  - Cancel while idle: no effect.
- The timeout counter is independent of mon_reset_n.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- clock_and_reset_pkg holds:
  - mon_state_e enum (WAIT_RST, IN_RST, POST_RST);
  - a saturating-increment function parameterised by width.
- One sub-module, clock_timeout_counter (CNT_W), owns tmo_load/tmo_count/tmo_cancel → tmo_busy/tmo_remaining/tmo_expired/tmo_toggle.
- The top holds the measurement FSM and instantiates the sub-module.

Test Plan:
1. Hold reset 3 cycles, mon_reset_n low for 5 edges then high → rst_len=5; rst_len_valid high exactly one cycle; rst_seen=1; rst_short_err=0; cycles_since_rst=0,1,2… after release.
2. MIN_RESET_CYCLES=2, one-edge low pulse → rst_len=1, rst_short_err=1. A following 4-edge pulse → rst_len=4 and rst_short_err stays 1 until reset.
3. tmo_load with count 3 → busy 3 cycles; remaining 3,2,1,0; tmo_expired pulses when remaining reaches 0; tmo_toggle 0→1. Then load 0 → expired next cycle, toggle 1→0.
4. Load 10, cancel after 4 cycles → busy=0, remaining=0, no pulse, toggle unchanged. Load 10 with cancel on the same edge → loads 10.
5. Load 2, then reload 5 on the edge remaining goes 1→0 → no pulse; expiry 5 cycles after the reload.
6. CNT_W=4: hold mon_reset_n low 20 edges → rst_len=15. Then assert reset mid-pulse and mid-timeout → all outputs 0 next cycle; FSM=WAIT_RST; a low mon_reset_n after reset release counts as a new falling edge.
